sdi_mode_ce_gen: RTL and testbench
==================================

// Module: sdi_mode_ce_gen
// PURPOSE
//  Synthesisable successor to the per-mode SDI testbench clock generator. Runs from one fixed
//  reference clock (297 MHz nominal) and emits a per-mode sample clock-enable (ce). Rates come from
//  a fractional N/D accumulator: 74.25/148.5/297 MHz equivalents, integer or /1.001.
//  Mode changes are glitch-free and take effect only at a ce boundary. Feeds SDI TX/RX datapaths and benches.
// PARAMETERS
//  STEP_UNIT  1000   accumulator increment per rate unit (HD=1x, SD/3G/6G/other=2x, 12G=4x)
//  DEN_INT    4000   accumulator modulus, integer rates
//  DEN_FRAC   4004   accumulator modulus, /1.001 rates
//  ACC_W      13     accumulator width; must hold DEN_FRAC-1
//  CNT_W      16     width of ce_cnt
//  MODE_RST   3'b000 mode after reset (HD)
// PORTS
//  clk        in   1      reference clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      run enable
//  mode_req   in   1      1-cycle strobe: load mode_in/frac_in
//  mode_in    in   3      000 HD, 001 SD, 010 3G, 100 6G, 101 12G, 110 12G_1, others -> 148.5 class
//  frac_in    in   1      1 = /1.001 rate
//  ce         out  1      registered sample enable, 1-cycle pulses
//  ce_cnt     out  CNT_W  free-running count of ce pulses, wraps to 0
//  mode_cur   out  3      mode currently driving ce
//  frac_cur   out  1      frac currently driving ce
//  mode_ack   out  1      1-cycle pulse, cycle after a request is applied
//  busy       out  1      high while a request is pending (state PEND)
// BEHAVIOUR
//  Reset: ce=0, ce_cnt=0, acc=0, mode_cur=MODE_RST, frac_cur=0, mode_ack=0, busy=0, state IDLE.
//  step = STEP_UNIT*k, k: HD=1, 12G=4, all other codes=2 (MODE_12G_1 = 148.5 class); den = frac ? DEN_FRAC : DEN_INT.
//  Each RUN/PEND cycle: sum=acc+step (ACC_W+1 bits); sum>=den -> acc<=sum-den, ce<=1;
//   else acc<=sum, ce<=0. ce registered -> 1-cycle latency from wrap decision.
//  HD int: first ce on 4th clk after en rises, then every 4th; 12G int: every cycle;
//   12G frac: 1000 ce per 1001 clks; 3G frac: 1000 ce per 2002 clks.
//  States: IDLE (en=0): acc held at 0, ce=0; mode_req applied immediately (mode_ack next cycle).
//   IDLE->RUN when en=1. RUN: mode_req captured into pending regs -> PEND, busy=1.
//   PEND: at the cycle a wrap (ce<=1) is decided, pending mode/frac become current, acc<=0
//   (remainder discarded), -> RUN, busy<=0, mode_ack next cycle. That ce still issues.
//  Any state, en=0 -> IDLE next cycle: acc<=0, ce<=0; a pending request is applied at once (ack).
//  mode_req while PEND: overwrites pending, latest wins, one ack only.
//  mode_req on the same cycle as the PEND wrap: new values applied at that wrap.
//  mode_req same value as current: still handled, still acked.
//  ce_cnt increments with every ce=1 output; wraps 2^CNT_W-1 -> 0.
//  Reset mid-operation: all outputs return to reset values asynchronously; pending request lost.
// TESTING
//  1 rst_n low 5 clk, en=1, HD int -> ce high on clk 4,8,12..; ce_cnt=25 after 100 clk.
//  2 mode 101 frac=1 for 1001 clk from IDLE -> exactly 1000 ce, one missing pulse.
//  3 mode 011 int -> ce every 2nd clk, mode_cur=011; mode 010 frac -> 1000 ce in 2002 clk.
//  4 HD run, req 12G at acc=1000 -> busy 2 clk, switch at next wrap, mode_ack, then ce every clk.
//  5 PEND: req 3G then req 12G before wrap -> one mode_ack, mode_cur=101.
//  6 rst_n low mid-run (async, between edges) -> ce=0, ce_cnt=0, mode_cur=000 immediately; en low -> ce=0 next clk.

Source files
------------

// File: rtl/sdi_mode_ce_gen_if.sv
// Control/status bundle for the SDI per-mode clock-enable generator.
// The master side requests modes and the slave side reports the running rate.
interface sdi_mode_ce_gen_if #(
    parameter int CNT_W = 16
) ();
    logic             en;
    logic             mode_req;
    logic [2:0]       mode_in;
    logic             frac_in;
    logic             ce;
    logic [CNT_W-1:0] ce_cnt;
    logic [2:0]       mode_cur;
    logic             frac_cur;
    logic             mode_ack;
    logic             busy;

    modport master (
        output en, mode_req, mode_in, frac_in,
        input  ce, ce_cnt, mode_cur, frac_cur, mode_ack, busy
    );

    modport slave (
        input  en, mode_req, mode_in, frac_in,
        output ce, ce_cnt, mode_cur, frac_cur, mode_ack, busy
    );
endinterface

// File: rtl/sdi_mode_ce_gen.sv
// Per-mode SDI sample clock-enable generator.
// A fractional N/D accumulator running on one reference clock produces the
// 74.25/148.5/297 MHz sample rates (integer or /1.001).
// A mode request is applied only at a ce boundary, so ce never glitches.
module sdi_mode_ce_gen #(
    parameter int unsigned STEP_UNIT = 1000,
    parameter int unsigned DEN_INT   = 4000,
    parameter int unsigned DEN_FRAC  = 4004,
    parameter int          ACC_W     = 13,
    parameter int          CNT_W     = 16,
    parameter logic [2:0]  MODE_RST  = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    sdi_mode_ce_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Accumulator increment for a mode: HD is the 1x rate, 12G is 4x,
    // and every other code (12G_1 included) runs in the 148.5 class.
    function automatic logic [ACC_W:0] step_of(input logic [2:0] mode);
        logic [ACC_W:0] unit_v;
        unit_v = STEP_UNIT[ACC_W:0];
        case (mode)
            3'b000:  step_of = unit_v;
            3'b101:  step_of = unit_v << 2;
            default: step_of = unit_v << 1;
        endcase
    endfunction

    state_t           state_r,    state_nx;
    logic [ACC_W-1:0] acc_r,      acc_nx;
    logic             ce_r,       ce_nx;
    logic [CNT_W-1:0] cnt_r,      cnt_nx;
    logic [2:0]       mode_r,     mode_nx;
    logic             frac_r,     frac_nx;
    logic [2:0]       pmode_r,    pmode_nx;
    logic             pfrac_r,    pfrac_nx;
    logic             ack_r,      ack_nx;
    logic             busy_r,     busy_nx;

    logic [ACC_W:0]   step_s;
    logic [ACC_W:0]   den_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W:0]   diff_s;
    logic             wrap_s;

    // Accumulator arithmetic for the rate currently in force.
    always_comb begin
        step_s = step_of(mode_r);
        if (frac_r) begin
            den_s = DEN_FRAC[ACC_W:0];
        end else begin
            den_s = DEN_INT[ACC_W:0];
        end
        sum_s  = {1'b0, acc_r} + step_s;
        diff_s = sum_s - den_s;
        wrap_s = (sum_s >= den_s);
    end

    // Next-state, accumulator and mode-switch decisions.
    always_comb begin
        state_nx = state_r;
        acc_nx   = acc_r;
        ce_nx    = 1'b0;
        cnt_nx   = cnt_r;
        mode_nx  = mode_r;
        frac_nx  = frac_r;
        pmode_nx = pmode_r;
        pfrac_nx = pfrac_r;
        ack_nx   = 1'b0;

        if (!bus.en) begin
            // Stopped: clear the phase; any request (new or pending) lands now.
            state_nx = ST_IDLE;
            acc_nx   = {ACC_W{1'b0}};
            if (bus.mode_req) begin
                mode_nx = bus.mode_in;
                frac_nx = bus.frac_in;
                ack_nx  = 1'b1;
            end else if (state_r == ST_PEND) begin
                mode_nx = pmode_r;
                frac_nx = pfrac_r;
                ack_nx  = 1'b1;
            end else begin
                ack_nx  = 1'b0;
            end
        end else begin
            if (wrap_s) begin
                acc_nx = diff_s[ACC_W-1:0];
                ce_nx  = 1'b1;
                cnt_nx = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                acc_nx = sum_s[ACC_W-1:0];
                ce_nx  = 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    state_nx = ST_RUN;
                    if (bus.mode_req) begin
                        mode_nx = bus.mode_in;
                        frac_nx = bus.frac_in;
                        ack_nx  = 1'b1;
                    end else begin
                        ack_nx  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.mode_req) begin
                        pmode_nx = bus.mode_in;
                        pfrac_nx = bus.frac_in;
                        state_nx = ST_PEND;
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
                ST_PEND: begin
                    if (wrap_s) begin
                        // Switch on the ce boundary; the remainder is dropped
                        // so the new rate starts from a clean phase.
                        if (bus.mode_req) begin
                            mode_nx = bus.mode_in;
                            frac_nx = bus.frac_in;
                        end else begin
                            mode_nx = pmode_r;
                            frac_nx = pfrac_r;
                        end
                        acc_nx   = {ACC_W{1'b0}};
                        ack_nx   = 1'b1;
                        state_nx = ST_RUN;
                    end else if (bus.mode_req) begin
                        pmode_nx = bus.mode_in;
                        pfrac_nx = bus.frac_in;
                    end else begin
                        state_nx = ST_PEND;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    acc_nx   = {ACC_W{1'b0}};
                    ce_nx    = 1'b0;
                    cnt_nx   = cnt_r;
                end
            endcase
        end

        busy_nx = (state_nx == ST_PEND);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            ce_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            mode_r  <= MODE_RST;
            frac_r  <= 1'b0;
            pmode_r <= MODE_RST;
            pfrac_r <= 1'b0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            acc_r   <= acc_nx;
            ce_r    <= ce_nx;
            cnt_r   <= cnt_nx;
            mode_r  <= mode_nx;
            frac_r  <= frac_nx;
            pmode_r <= pmode_nx;
            pfrac_r <= pfrac_nx;
            ack_r   <= ack_nx;
            busy_r  <= busy_nx;
        end
    end

    assign bus.ce       = ce_r;
    assign bus.ce_cnt   = cnt_r;
    assign bus.mode_cur = mode_r;
    assign bus.frac_cur = frac_r;
    assign bus.mode_ack = ack_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_sdi_mode_ce_gen.sv
// Self-checking bench for sdi_mode_ce_gen: directed table, rate sequences,
// counter wrap, async reset and a randomized run against a reference model.
`timescale 1ns/1ps
module tb_sdi_mode_ce_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdi_mode_ce_gen_if #(.CNT_W(16)) bus ();

    sdi_mode_ce_gen #(
        .STEP_UNIT(1000), .DEN_INT(4000), .DEN_FRAC(4004),
        .ACC_W(13), .CNT_W(16), .MODE_RST(3'b000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase kept as a plain integer in [0, den).
    int       m_phase, m_cnt;
    int       m_mode, m_frac, m_pmode, m_pfrac;
    bit       m_running, m_pending, m_ce, m_ack;

    function automatic int rate_of(input int mode);
        if (mode == 0) return 1000;
        if (mode == 5) return 4000;
        return 2000;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_mode = 0; m_frac = 0;
        m_pmode = 0; m_pfrac = 0; m_running = 0; m_pending = 0;
        m_ce = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit en, input bit req, input int mi, input int fi);
        int period;
        int total;
        period = m_frac ? 4004 : 4000;
        m_ce = 0;
        m_ack = 0;
        if (!en) begin
            m_phase = 0;
            if (req) begin
                m_mode = mi; m_frac = fi; m_ack = 1;
            end else if (m_pending) begin
                m_mode = m_pmode; m_frac = m_pfrac; m_ack = 1;
            end
            m_pending = 0;
            m_running = 0;
        end else begin
            total   = m_phase + rate_of(m_mode);
            m_ce    = (total / period) != 0;
            m_phase = total % period;
            if (m_ce) m_cnt = (m_cnt + 1) % 65536;
            if (!m_running) begin
                m_running = 1;
                if (req) begin m_mode = mi; m_frac = fi; m_ack = 1; end
            end else if (!m_pending) begin
                if (req) begin m_pending = 1; m_pmode = mi; m_pfrac = fi; end
            end else if (m_ce) begin
                if (req) begin m_mode = mi; m_frac = fi; end
                else     begin m_mode = m_pmode; m_frac = m_pfrac; end
                m_ack = 1; m_phase = 0; m_pending = 0;
            end else if (req) begin
                m_pmode = mi; m_pfrac = fi;
            end
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, sample 1 ns later.
    task automatic cycle(input bit en, input bit req, input logic [2:0] mi, input bit fi);
        bus.en = en; bus.mode_req = req; bus.mode_in = mi; bus.frac_in = fi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.mode_req = 1'b0; bus.mode_in = 3'b000; bus.frac_in = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       req;
        logic [2:0] mi;
        logic       fi;
        logic       ce;
        logic       busy;
        logic [2:0] mc;
        logic       fc;
        logic       ack;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic req, input logic [2:0] mi, input logic fi,
                                input logic ce, input logic busy, input logic [2:0] mc,
                                input logic fc, input logic ack);
        vec_t v;
        v.en = en; v.req = req; v.mi = mi; v.fi = fi;
        v.ce = ce; v.busy = busy; v.mc = mc; v.fc = fc; v.ack = ack;
        return v;
    endfunction

    vec_t tbl [28];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits, miss, zeros;
        logic [31:0] act_v, exp_v;

        //           en  req  mi      fi    ce  busy mc     fc    ack
        tbl[0]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b0);
        tbl[1]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b0);
        tbl[2]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b0);
        tbl[3]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b000,1'b0,1'b0);
        tbl[4]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b0);
        tbl[5]  = mk(1'b1,1'b1,3'b101,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0);
        tbl[6]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0);
        tbl[7]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b101,1'b0,1'b1);
        tbl[8]  = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b101,1'b0,1'b0);
        tbl[9]  = mk(1'b1,1'b1,3'b000,1'b0, 1'b1,1'b1,3'b101,1'b0,1'b0);
        tbl[10] = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b000,1'b0,1'b1);
        tbl[11] = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b000,1'b0,1'b0);
        tbl[12] = mk(1'b1,1'b1,3'b010,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0);
        tbl[13] = mk(1'b1,1'b1,3'b101,1'b0, 1'b0,1'b1,3'b000,1'b0,1'b0);
        tbl[14] = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b101,1'b0,1'b1);
        tbl[15] = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b101,1'b0,1'b0);
        tbl[16] = mk(1'b1,1'b1,3'b010,1'b1, 1'b1,1'b1,3'b101,1'b0,1'b0);
        tbl[17] = mk(1'b1,1'b1,3'b110,1'b0, 1'b1,1'b0,3'b110,1'b0,1'b1);
        tbl[18] = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b110,1'b0,1'b0);
        tbl[19] = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b110,1'b0,1'b0);
        tbl[20] = mk(1'b1,1'b1,3'b000,1'b1, 1'b0,1'b1,3'b110,1'b0,1'b0);
        tbl[21] = mk(1'b0,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b000,1'b1,1'b1);
        tbl[22] = mk(1'b0,1'b1,3'b011,1'b0, 1'b0,1'b0,3'b011,1'b0,1'b1);
        tbl[23] = mk(1'b0,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b011,1'b0,1'b0);
        tbl[24] = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b011,1'b0,1'b0);
        tbl[25] = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b011,1'b0,1'b0);
        tbl[26] = mk(1'b1,1'b0,3'b000,1'b0, 1'b0,1'b0,3'b011,1'b0,1'b0);
        tbl[27] = mk(1'b1,1'b0,3'b000,1'b0, 1'b1,1'b0,3'b011,1'b0,1'b0);

        // Reset values.
        do_reset();
        check("reset outputs",
              {20'd0, bus.ce, bus.busy, bus.mode_ack, bus.frac_cur, bus.mode_cur, 5'd0},
              32'd0);
        check("reset ce_cnt", {16'd0, bus.ce_cnt}, 32'd0);

        // Directed table: HD run, deferred switch, overwrite, same-cycle request, stop.
        for (int i = 0; i < 28; i++) begin
            cycle(tbl[i].en, tbl[i].req, tbl[i].mi, tbl[i].fi);
            act_v = {25'd0, bus.ce, bus.busy, bus.mode_cur, bus.frac_cur, bus.mode_ack};
            exp_v = {25'd0, tbl[i].ce, tbl[i].busy, tbl[i].mc, tbl[i].fc, tbl[i].ack};
            check($sformatf("table row %0d {ce,busy,mode,frac,ack}", i), act_v, exp_v);
        end

        // HD integer: ce on every 4th clock, 25 pulses in 100 clocks.
        do_reset();
        miss = 0;
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b1, 1'b0, 3'b000, 1'b0);
            if (bus.ce !== ((i % 4) == 0)) miss++;
        end
        check("HD ce misplaced count", miss, 32'd0);
        check("HD ce_cnt after 100", {16'd0, bus.ce_cnt}, 32'd25);

        // 12G /1.001: 1000 pulses in 1001 clocks, one missing.
        do_reset();
        cycle(1'b0, 1'b1, 3'b101, 1'b1);
        hits = 0; zeros = 0;
        for (int i = 0; i < 1001; i++) begin
            cycle(1'b1, 1'b0, 3'b000, 1'b0);
            if (bus.ce === 1'b1) hits++; else zeros++;
        end
        check("12G frac ce in 1001", hits, 32'd1000);
        check("12G frac missing pulses", zeros, 32'd1);
        check("12G frac ce_cnt", {16'd0, bus.ce_cnt}, 32'd1000);

        // 3G /1.001: 1000 pulses in 2002 clocks.
        do_reset();
        cycle(1'b0, 1'b1, 3'b010, 1'b1);
        check("3G frac mode_cur", {28'd0, bus.frac_cur, bus.mode_cur}, 32'h0000000A);
        hits = 0;
        for (int i = 0; i < 2002; i++) begin
            cycle(1'b1, 1'b0, 3'b000, 1'b0);
            if (bus.ce === 1'b1) hits++;
        end
        check("3G frac ce in 2002", hits, 32'd1000);

        // ce_cnt wrap at 12G integer (one pulse per clock).
        do_reset();
        cycle(1'b0, 1'b1, 3'b101, 1'b0);
        for (int i = 0; i < 65535; i++) cycle(1'b1, 1'b0, 3'b000, 1'b0);
        check("ce_cnt at max", {16'd0, bus.ce_cnt}, 32'd65535);
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        check("ce_cnt wrap to 0", {16'd0, bus.ce_cnt}, 32'd0);

        // Asynchronous reset between edges while running 12G.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset {ce,mode_cur,busy,ack}",
              {26'd0, bus.ce, bus.mode_cur, bus.busy, bus.mode_ack}, 32'd0);
        check("async reset ce_cnt", {16'd0, bus.ce_cnt}, 32'd0);
        do_reset();

        // Randomized run against the reference model.
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          r_en, r_req;
            logic [2:0]  r_mi;
            bit          r_fi;
            r_en  = ($urandom_range(0, 99) < 93);
            r_req = ($urandom_range(0, 99) < 6);
            r_mi  = 3'($urandom_range(0, 7));
            r_fi  = 1'($urandom_range(0, 1));
            model_step(r_en, r_req, int'(r_mi), int'(r_fi));
            cycle(r_en, r_req, r_mi, r_fi);
            act_v = {3'd0, bus.ce, bus.busy, bus.mode_ack, bus.frac_cur, bus.mode_cur, bus.ce_cnt};
            exp_v = {3'd0, m_ce, m_pending, m_ack, 1'(m_frac), 3'(m_mode), 16'(m_cnt)};
            check($sformatf("random cycle %0d {ce,busy,ack,frac,mode,cnt}", i), act_v, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
